glue_clk_seq: RTL and testbench



---
 rtl/glue_clk_seq.sv | 161 ++++++++++++++++
 tb/tb_glue_clk_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/glue_clk_seq.sv
// Board-glue clock-enable generator and reset-release sequencer.
// Produces NUM_CH programmable-rate strobes (main and mid-period) and the TRST/system-reset/CPU-start sequence.

module glue_clk_seq_ch #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             xck_x1,
  input  logic             xxclr,
  input  logic             load,
  input  logic             run,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] phase,
  output logic             ce_out,
  output logic             ce_phi2
);

  logic [DIV_W-1:0] div_sh;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] phase_clamped;
  logic             at_tc;

  // A start phase beyond the period is clamped so cnt never exceeds div_sh.
  assign phase_clamped = (phase > div) ? div : phase;
  assign at_tc         = (cnt == div_sh);

  always_ff @(posedge xck_x1 or negedge xxclr) begin
    if (!xxclr) begin
      div_sh  <= DIV_W'(DEFAULT_DIV);
      cnt     <= '0;
      ce_out  <= 1'b0;
      ce_phi2 <= 1'b0;
    end else if (load) begin
      div_sh  <= div;
      cnt     <= phase_clamped;
      ce_out  <= 1'b0;
      ce_phi2 <= 1'b0;
    end else if (!run || !en) begin
      ce_out  <= 1'b0;
      ce_phi2 <= 1'b0;
    end else begin
      ce_out  <= at_tc;
      ce_phi2 <= (cnt == (div_sh >> 1));
      cnt     <= at_tc ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// state  | meaning
// RST    | waiting for synchronised TRST release; everything held off
// DELAY  | system reset released; counting START_DELAY cycles
// START  | single cycle with the CPU start pulse high
// RUN    | sequencing done; ready high, dividers counting
module glue_clk_seq #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int RST_SYNC    = 2,
  parameter int START_DELAY = 16,
  parameter int DEFAULT_DIV = 1
) (
  input  logic                    xck_x1,
  input  logic                    xxclr,
  input  logic [NUM_CH*DIV_W-1:0] cfg_div,
  input  logic [NUM_CH*DIV_W-1:0] cfg_phase,
  input  logic                    cfg_load,
  input  logic [NUM_CH-1:0]       cfg_ch_en,
  output logic [NUM_CH-1:0]       ce_out,
  output logic [NUM_CH-1:0]       ce_phi2,
  output logic                    ejtag_trst_n,
  output logic                    sys_rst_n,
  output logic                    xctrl_cpu_start,
  output logic                    ready
);

  localparam int DCNT_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(START_DELAY - 1);

  typedef enum logic [1:0] {
    ST_RST,
    ST_DELAY,
    ST_START,
    ST_RUN
  } state_t;

  state_t              state;
  logic [DCNT_W-1:0]   dcnt;
  logic [RST_SYNC-1:0] rst_sync;
  logic                run;

  // Assertion is immediate; release ripples through the chain.
  always_ff @(posedge xck_x1 or negedge xxclr) begin
    if (!xxclr) begin
      rst_sync <= '0;
    end else begin
      rst_sync <= {rst_sync[RST_SYNC-2:0], 1'b1};
    end
  end

  assign ejtag_trst_n = rst_sync[RST_SYNC-1];

  always_ff @(posedge xck_x1 or negedge xxclr) begin
    if (!xxclr) begin
      state           <= ST_RST;
      dcnt            <= '0;
      sys_rst_n       <= 1'b0;
      xctrl_cpu_start <= 1'b0;
      ready           <= 1'b0;
    end else begin
      case (state)
        ST_RST: begin
          if (ejtag_trst_n) begin
            state     <= ST_DELAY;
            sys_rst_n <= 1'b1;
            dcnt      <= '0;
          end
        end
        ST_DELAY: begin
          if (dcnt == DCNT_LAST) begin
            state           <= ST_START;
            xctrl_cpu_start <= 1'b1;
          end else begin
            dcnt <= dcnt + DCNT_W'(1);
          end
        end
        ST_START: begin
          state           <= ST_RUN;
          xctrl_cpu_start <= 1'b0;
          ready           <= 1'b1;
        end
        ST_RUN: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RST;
        end
      endcase
    end
  end

  assign run = (state == ST_RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    glue_clk_seq_ch #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .xck_x1  (xck_x1),
      .xxclr   (xxclr),
      .load    (cfg_load),
      .run     (run),
      .en      (cfg_ch_en[i]),
      .div     (cfg_div[i*DIV_W +: DIV_W]),
      .phase   (cfg_phase[i*DIV_W +: DIV_W]),
      .ce_out  (ce_out[i]),
      .ce_phi2 (ce_phi2[i])
    );
  end

endmodule

// File: tb/tb_glue_clk_seq.sv
// Bench for glue_clk_seq: edge-count sequencer model plus modulo-position strobe model,
// checked every cycle, with literal timing pins from the power-on and load scenarios.

module tb_glue_clk_seq;

  localparam int NUM_CH      = 4;
  localparam int DIV_W       = 8;
  localparam int RST_SYNC    = 2;
  localparam int START_DELAY = 16;
  localparam int DEFAULT_DIV = 1;
  localparam int RUN_N       = RST_SYNC + START_DELAY + 2;

  logic                    clk;
  logic                    xxclr;
  logic [NUM_CH*DIV_W-1:0] cfg_div;
  logic [NUM_CH*DIV_W-1:0] cfg_phase;
  logic                    cfg_load;
  logic [NUM_CH-1:0]       cfg_ch_en;
  logic [NUM_CH-1:0]       ce_out;
  logic [NUM_CH-1:0]       ce_phi2;
  logic                    ejtag_trst_n;
  logic                    sys_rst_n;
  logic                    xctrl_cpu_start;
  logic                    ready;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  glue_clk_seq #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .RST_SYNC    (RST_SYNC),
    .START_DELAY (START_DELAY),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .xck_x1          (clk),
    .xxclr           (xxclr),
    .cfg_div         (cfg_div),
    .cfg_phase       (cfg_phase),
    .cfg_load        (cfg_load),
    .cfg_ch_en       (cfg_ch_en),
    .ce_out          (ce_out),
    .ce_phi2         (ce_phi2),
    .ejtag_trst_n    (ejtag_trst_n),
    .sys_rst_n       (sys_rst_n),
    .xctrl_cpu_start (xctrl_cpu_start),
    .ready           (ready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish, got=running want=done");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: sequencer outputs follow from the number of edges since release;
  // a strobe channel's position is (start phase + counted edges) mod (d+1).
  int n;
  int md[NUM_CH];
  int mp0[NUM_CH];
  int mk[NUM_CH];
  int m_d, m_p, m_pos;
  bit m_run;
  logic [NUM_CH-1:0] m_ce, m_phi2;
  logic m_trst, m_sys, m_start, m_ready;

  always @(posedge clk or negedge xxclr) begin
    if (!xxclr) begin
      n = 0;
      for (int i = 0; i < NUM_CH; i++) begin
        md[i] = DEFAULT_DIV; mp0[i] = 0; mk[i] = 0;
      end
      m_ce = '0;
      m_phi2 = '0;
    end else begin
      m_run = (n >= RUN_N);
      for (int i = 0; i < NUM_CH; i++) begin
        m_d = int'(cfg_div[i*DIV_W +: DIV_W]);
        m_p = int'(cfg_phase[i*DIV_W +: DIV_W]);
        if (cfg_load) begin
          md[i] = m_d;
          mp0[i] = (m_p < m_d) ? m_p : m_d;
          mk[i] = 0;
          m_ce[i] = 1'b0;
          m_phi2[i] = 1'b0;
        end else if (m_run && cfg_ch_en[i]) begin
          m_pos = (mp0[i] + mk[i]) % (md[i] + 1);
          m_ce[i] = (m_pos == md[i]);
          m_phi2[i] = (m_pos == md[i] / 2);
          mk[i]++;
        end else begin
          m_ce[i] = 1'b0;
          m_phi2[i] = 1'b0;
        end
      end
      if (n < 100000) n++;
    end
    m_trst  = (n >= RST_SYNC);
    m_sys   = (n >= RST_SYNC + 1);
    m_start = (n == RST_SYNC + START_DELAY + 1);
    m_ready = (n >= RUN_N);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ce_out",    32'(ce_out),          32'(m_ce));
      chk("ce_phi2",   32'(ce_phi2),         32'(m_phi2));
      chk("trst_n",    32'(ejtag_trst_n),    32'(m_trst));
      chk("sys_rst_n", 32'(sys_rst_n),       32'(m_sys));
      chk("cpu_start", 32'(xctrl_cpu_start), 32'(m_start));
      chk("ready",     32'(ready),           32'(m_ready));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input int d, input int p);
    cfg_div[i*DIV_W +: DIV_W]   = 8'(d);
    cfg_phase[i*DIV_W +: DIV_W] = 8'(p);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ce"},    32'(ce_out),          32'(0));
    chk({nm, "_phi2"},  32'(ce_phi2),         32'(0));
    chk({nm, "_trst"},  32'(ejtag_trst_n),    32'(0));
    chk({nm, "_sys"},   32'(sys_rst_n),       32'(0));
    chk({nm, "_start"}, 32'(xctrl_cpu_start), 32'(0));
    chk({nm, "_ready"}, 32'(ready),           32'(0));
  endtask

  // Called just after an edge; that edge is edge 0, release happens now.
  task automatic power_on(input bit hold_load, input int last);
    xxclr = 1'b1;
    for (int e = 1; e <= last; e++) begin
      tick();
      if (e == 1)  chk("pin_trst_e1", 32'(ejtag_trst_n), 32'(0));
      if (e == 2)  chk("pin_trst_e2", 32'(ejtag_trst_n), 32'(1));
      if (e == 2)  chk("pin_sys_e2", 32'(sys_rst_n), 32'(0));
      if (e == 3)  chk("pin_sys_e3", 32'(sys_rst_n), 32'(1));
      if (e == 18) chk("pin_start_e18", 32'(xctrl_cpu_start), 32'(0));
      if (e == 19) chk("pin_start_e19", 32'(xctrl_cpu_start), 32'(1));
      if (e == 19) chk("pin_ready_e19", 32'(ready), 32'(0));
      if (e == 20) chk("pin_start_e20", 32'(xctrl_cpu_start), 32'(0));
      if (e == 20) chk("pin_ready_e20", 32'(ready), 32'(1));
      if (e == 21) chk("pin_ce_e21", 32'(ce_out), 32'(0));
      if (e == 22) chk("pin_ce_e22", 32'(ce_out), hold_load ? 32'(0) : 32'hF);
      if (e == 23) chk("pin_ce_e23", 32'(ce_out), hold_load ? 32'hF : 32'(0));
      if (hold_load && e == 4) begin
        for (int i = 0; i < NUM_CH; i++) set_ch(i, 2, 0);
        cfg_load = 1'b1;
      end
      if (hold_load && e == 15) cfg_load = 1'b0;
    end
  endtask

  initial begin
    xxclr = 1'b0;
    cfg_load = 1'b0;
    cfg_ch_en = '1;
    cfg_div = '0;
    cfg_phase = '0;
    repeat (3) tick();
    chk_en = 1;
    chk_all_zero("reset");

    power_on(1'b0, 23);
    repeat (5) tick();

    // Mixed load: ch0 d4 p0, ch1 d4 p3, ch2 d0, ch3 d7 p9 (clamped).
    set_ch(0, 4, 0); set_ch(1, 4, 3); set_ch(2, 0, 0); set_ch(3, 7, 9);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("load_L_ce", 32'(ce_out), 32'(0));
    chk("load_L_phi2", 32'(ce_phi2), 32'(0));
    tick(); chk("load_L1_ce", 32'(ce_out), 32'b1100);
    tick(); chk("load_L2_ce", 32'(ce_out), 32'b0110);
    tick(); chk("load_L3_ce", 32'(ce_out), 32'b0100);
    chk("load_L3_phi2", 32'(ce_phi2), 32'b0101);
    tick(); chk("load_L4_ce", 32'(ce_out), 32'b0100);
    tick(); chk("load_L5_ce", 32'(ce_out), 32'b0101);
    repeat (4) tick();
    chk("load_L9_ce", 32'(ce_out), 32'b1100);
    tick(); chk("load_L10_ce", 32'(ce_out), 32'b0101);

    // Enable gap on ch0 for three edges.
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 4, 0);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    tick();
    cfg_ch_en[0] = 1'b0;
    tick(); chk("gap_2_ce0", 32'(ce_out[0]), 32'(0));
    tick(); chk("gap_3_phi2_0", 32'(ce_phi2[0]), 32'(0));
    tick(); chk("gap_4_ce0", 32'(ce_out[0]), 32'(0));
    cfg_ch_en[0] = 1'b1;
    tick(); chk("gap_5_ce", 32'(ce_out), 32'b1110);
    tick(); chk("gap_6_phi2_0", 32'(ce_phi2[0]), 32'(1));
    tick();
    tick(); chk("gap_8_ce", 32'(ce_out), 32'b0001);
    repeat (5) tick();
    chk("gap_13_ce", 32'(ce_out), 32'b0001);

    // Load landing on the terminal-count edge.
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < NUM_CH; i++) set_ch(i, 4, 2);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("tc_load_ce", 32'(ce_out), 32'(0));
    tick(); tick();
    chk("tc_load_7_ce", 32'(ce_out), 32'(0));
    tick(); chk("tc_load_8_ce", 32'(ce_out), 32'hF);

    // Randomised loads, phases and enables.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        for (int i = 0; i < NUM_CH; i++)
          set_ch(i, int'($urandom_range(0, 9)), int'($urandom_range(0, 12)));
        cfg_load = 1'b1;
      end else begin
        cfg_load = 1'b0;
      end
      if ($urandom_range(0, 7) == 0)
        cfg_ch_en[$urandom_range(0, NUM_CH - 1)] ^= 1'b1;
      tick();
    end
    cfg_load = 1'b0;
    cfg_ch_en = '1;

    // Reset during RUN, then replay.
    #1 xxclr = 1'b0;
    #1 chk_all_zero("rst_run");
    tick();
    power_on(1'b0, 19);

    // Reset during START, then replay.
    #1 xxclr = 1'b0;
    #1 chk_all_zero("rst_start");
    tick();
    power_on(1'b0, 23);
    repeat (4) tick();

    // cfg_load held through DELAY.
    #1 xxclr = 1'b0;
    tick();
    power_on(1'b1, 23);
    repeat (10) tick();

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
